// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: word-wide data-memory port between the LSU and data memory.
// master (LSU): drives req/we/addr/wdata/wmask; slave (memory): gnt/rvalid/rdata.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [ADDR_W-1:0]     o_mem_addr;
  logic [DATA_W-1:0]     o_mem_wdata;
  logic [DATA_W/8-1:0]   o_mem_wmask;
  logic                  i_mem_gnt;
  logic                  i_mem_rvalid;
  logic [DATA_W-1:0]     i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr,
    output o_mem_wdata, o_mem_wmask,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr,
    input  o_mem_wdata, o_mem_wmask,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle RV32E load/store unit (IDLE->REQ->WAIT->DONE).
// Ports: clk/rst (sync, active-high); core side i_valid/i_ld/i_st/i_funct3/
// i_addr/i_wdata in, o_busy/o_done/o_rdata/o_err out; mem: lsu_ctrl_if.master.
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_ld,
  input  logic              i_st,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  lsu_ctrl_if.master        mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                ld_q, ld_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          off_q, off_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wmask_q, wmask_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                f3_ok;
  logic                misal;
  logic                illegal;
  logic [DATA_W-1:0]   st_data;
  logic [3:0]          st_mask;
  logic [DATA_W-1:0]   sh;
  logic [DATA_W-1:0]   ext;

  // Legality of the incoming request.
  always_comb begin
    f3_ok = i_ld ? (i_funct3 inside {3'b000, 3'b001, 3'b010,
                                     3'b100, 3'b101})
                 : (i_funct3 inside {3'b000, 3'b001, 3'b010});
    misal = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
            ((i_funct3[1:0] == 2'b10) & (i_addr[1:0] != 2'b00));
    illegal = (i_ld == i_st) | ~f3_ok | misal;
  end

  // Store lane placement: data replicated, mask selects the lanes.
  always_comb begin
    st_data = i_wdata;
    st_mask = 4'b1111;
    unique case (i_funct3[1:0])
      2'b00: begin
        st_data = {4{i_wdata[7:0]}};
        st_mask = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        st_data = {2{i_wdata[15:0]}};
        st_mask = 4'b0011 << i_addr[1:0];
      end
      default: begin
        st_data = i_wdata;
        st_mask = 4'b1111;
      end
    endcase
  end

  // Load extraction from the returned word.
  assign sh = mem.i_mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = sh;
    unique case (f3_q)
      3'b000:  ext = {{(DATA_W-8){sh[7]}}, sh[7:0]};
      3'b001:  ext = {{(DATA_W-16){sh[15]}}, sh[15:0]};
      3'b100:  ext = {{(DATA_W-8){1'b0}}, sh[7:0]};
      3'b101:  ext = {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: ext = mem.i_mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    f3_d    = f3_q;
    off_d   = off_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (i_valid) begin
          ld_d    = i_ld;
          f3_d    = i_funct3;
          off_d   = i_addr[1:0];
          we_d    = ~i_ld;
          addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
          wdata_d = i_ld ? i_wdata : st_data;
          wmask_d = i_ld ? 4'b0000 : st_mask;
          err_d   = illegal;
          rdata_d = '0;
          // Illegal requests finish without touching memory.
          state_d = illegal ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem.i_mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (mem.i_mem_rvalid) begin
          rdata_d = ld_q ? ext : '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ld_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= 4'b0000;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_done          = (state_q == DONE);
  assign o_busy          = (i_valid | (state_q != IDLE)) & ~o_done;
  assign o_rdata         = rdata_q;
  assign o_err           = err_q;
  assign mem.o_mem_req   = (state_q == REQ);
  assign mem.o_mem_we    = we_q;
  assign mem.o_mem_addr  = addr_q;
  assign mem.o_mem_wdata = wdata_q;
  assign mem.o_mem_wmask = wmask_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed + randomized checks of lsu_ctrl against a
// behavioural model of the access rules.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ld;
  logic        i_st;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_err;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) mem ();

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_ld     (i_ld),
    .i_st     (i_st),
    .i_funct3 (i_funct3),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_rdata  (o_rdata),
    .o_err    (o_err),
    .mem      (mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model of the access rules.
  function automatic bit ref_illegal(input bit ld, input bit st,
                                     input logic [2:0] f3,
                                     input logic [31:0] a);
    bit ok;
    int sz;
    if (ld == st) return 1'b1;
    if (ld) ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else    ok = (f3 <= 2);
    if (!ok) return 1'b1;
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] w);
    int unsigned k, v, b, h;
    k = a % 4;
    v = w / (32'd1 << (8 * k));
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_mask(input logic [2:0] f3,
                                           input logic [31:0] a);
    int k;
    k = a % 4;
    case (f3)
      3'd0:    return 32'(1 << k);
      3'd1:    return 32'(3 << k);
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3,
                                            input logic [31:0] w);
    case (f3)
      3'd0:    return (w % 256) * 32'h0101_0101;
      3'd1:    return (w % 65536) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  // One access: gd = cycles of grant delay, rd = cycles of response delay.
  task automatic access(input string tag, input bit ld, input bit st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int gd,
                        input int rd, input logic [31:0] rword);
    bit ill;
    ill = ref_illegal(ld, st, f3, a);
    @(posedge clk); #1;
    i_valid = 1'b1; i_ld = ld; i_st = st;
    i_funct3 = f3; i_addr = a; i_wdata = wd;
    @(negedge clk);
    chk({tag, ".busy0"}, o_busy, 1);
    chk({tag, ".done0"}, o_done, 0);
    chk({tag, ".req0"}, mem.o_mem_req, 0);
    if (ill) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, ".ill_done"}, o_done, 1);
      chk({tag, ".ill_err"}, o_err, 1);
      chk({tag, ".ill_req"}, mem.o_mem_req, 0);
      chk({tag, ".ill_busy"}, o_busy, 0);
    end else begin
      for (int g = 0; g <= gd; g++) begin
        @(posedge clk); #1;
        mem.i_mem_gnt = (g == gd);
        mem.i_mem_rvalid = 1'($urandom % 2);
        mem.i_mem_rdata = $urandom;
        @(negedge clk);
        chk({tag, ".req"}, mem.o_mem_req, 1);
        chk({tag, ".addr"}, mem.o_mem_addr, a - (a % 4));
        chk({tag, ".we"}, mem.o_mem_we, st);
        chk({tag, ".mask"}, mem.o_mem_wmask, ld ? 0 : ref_mask(f3, a));
        if (st) chk({tag, ".wdata"}, mem.o_mem_wdata, ref_wdata(f3, wd));
        chk({tag, ".busy_req"}, o_busy, 1);
        chk({tag, ".done_req"}, o_done, 0);
      end
      for (int r = 0; r <= rd; r++) begin
        @(posedge clk); #1;
        mem.i_mem_gnt = 1'b0;
        mem.i_mem_rvalid = (r == rd);
        mem.i_mem_rdata = (r == rd) ? rword : $urandom;
        @(negedge clk);
        chk({tag, ".req_wait"}, mem.o_mem_req, 0);
        chk({tag, ".busy_wait"}, o_busy, 1);
        chk({tag, ".done_wait"}, o_done, 0);
      end
      @(posedge clk); #1;
      mem.i_mem_rvalid = 1'b0;
      mem.i_mem_rdata = $urandom;
      @(negedge clk);
      chk({tag, ".done"}, o_done, 1);
      chk({tag, ".err"}, o_err, 0);
      chk({tag, ".rdata"}, o_rdata, ld ? ref_load(f3, a, rword) : 0);
      chk({tag, ".busy_done"}, o_busy, 0);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_addr = $urandom;
    i_wdata = $urandom;
    @(negedge clk);
    chk({tag, ".idle_done"}, o_done, 0);
    chk({tag, ".idle_busy"}, o_busy, 0);
  endtask

  initial begin
    bit ld, st;
    int sel;
    rst = 1'b1;
    i_valid = 1'b0; i_ld = 1'b0; i_st = 1'b0;
    i_funct3 = 3'd0; i_addr = '0; i_wdata = '0;
    mem.i_mem_gnt = 1'b0;
    mem.i_mem_rvalid = 1'b0;
    mem.i_mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.done", o_done, 0);
    chk("rst.busy", o_busy, 0);
    chk("rst.err", o_err, 0);
    chk("rst.rdata", o_rdata, 0);
    chk("rst.req", mem.o_mem_req, 0);
    chk("rst.we", mem.o_mem_we, 0);
    chk("rst.addr", mem.o_mem_addr, 0);
    chk("rst.wdata", mem.o_mem_wdata, 0);
    chk("rst.mask", mem.o_mem_wmask, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    access("lw", 1, 0, 3'd2, 32'h8000_0104, 0, 0, 0, 32'hDEAD_BEEF);
    access("lb", 1, 0, 3'd0, 32'h8000_0103, 0, 0, 0, 32'h80FF_7F01);
    access("lbu", 1, 0, 3'd4, 32'h8000_0103, 0, 0, 0, 32'h80FF_7F01);
    access("lh", 1, 0, 3'd1, 32'h8000_0102, 0, 0, 0, 32'h80FF_7F01);
    access("lhu", 1, 0, 3'd5, 32'h8000_0102, 0, 1, 0, 32'h80FF_7F01);
    access("sb", 0, 1, 3'd0, 32'h8000_0201, 32'h1234_56AB, 0, 0, 0);
    access("sh", 0, 1, 3'd1, 32'h8000_0202, 32'h1234_56AB, 1, 1, 0);
    access("sw", 0, 1, 3'd2, 32'h8000_0300, 32'hCAFE_F00D, 0, 0, 0);
    access("sw_mis", 0, 1, 3'd2, 32'h8000_0302, 32'h1, 0, 0, 0);
    access("lh_mis", 1, 0, 3'd1, 32'h8000_0101, 0, 0, 0, 0);
    access("nop", 0, 0, 3'd2, 32'h8000_0100, 0, 0, 0, 0);
    access("both", 1, 1, 3'd2, 32'h8000_0100, 0, 0, 0, 0);
    access("sbu", 0, 1, 3'd4, 32'h8000_0100, 0, 0, 0, 0);
    access("lw_slow", 1, 0, 3'd2, 32'h8000_0108, 0, 3, 1, 32'h0BAD_CAFE);

    // Reset while waiting for the response; late rvalid must be ignored.
    @(posedge clk); #1;
    i_valid = 1'b1; i_ld = 1'b1; i_st = 1'b0;
    i_funct3 = 3'd2; i_addr = 32'h8000_0400;
    @(posedge clk); #1;
    mem.i_mem_gnt = 1'b1;
    @(negedge clk);
    chk("rstw.req", mem.o_mem_req, 1);
    @(posedge clk); #1;
    mem.i_mem_gnt = 1'b0;
    @(negedge clk);
    chk("rstw.wait_req", mem.o_mem_req, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mem.i_mem_rvalid = 1'b1;
    mem.i_mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("rstw.done", o_done, 0);
    chk("rstw.req_idle", mem.o_mem_req, 0);
    chk("rstw.busy", o_busy, 0);
    @(posedge clk); #1;
    mem.i_mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rstw.done2", o_done, 0);
    chk("rstw.busy2", o_busy, 0);
    access("lw_after", 1, 0, 3'd2, 32'h8000_0410, 0, 0, 0, 32'h1357_9BDF);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      ld = (sel >= 5) || (sel == 1);
      st = (sel >= 2 && sel <= 4) || (sel == 1);
      access("rnd", ld, st, 3'($urandom % 8), $urandom, $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store unit for the RV32E NPC. It sits downstream of the execute stage and upstream of register write-back. It takes the ALU-computed effective address, store data and `funct3`, and runs a request/grant/response transaction on a word-wide data-memory port. It returns sign- or zero-extended load data with a one-cycle done pulse, and drives a stall so the core holds PC while an access is in flight.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. Fixed at 32; byte lanes are `DATA_W/8 = 4`.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `i_valid` in 1: access request from the core. Held stable, with all `i_*` operands, until `o_done`.
- `i_ld` in 1: the request is a load.
- `i_st` in 1: the request is a store.
- `i_funct3` in 3: access size and sign.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `i_addr` in ADDR_W: effective byte address (ALU output).
- `i_wdata` in DATA_W: store data (rs2), unshifted.
- `o_busy` in/out out 1: stall to the core, combinational: `(i_valid | state != IDLE) & ~o_done`.
- `o_done` out 1: one-cycle completion pulse.
- `o_rdata` out DATA_W: extended load result, valid while `o_done`=1. Reset value 0.
- `o_err` out 1: misaligned or illegal access, valid while `o_done`=1. Reset value 0.
- `o_mem_req` out 1: memory request. Reset value 0.
- `o_mem_we` out 1: write enable (1 = store). Reset value 0.
- `o_mem_addr` out ADDR_W: word-aligned address `{addr[31:2],2'b00}`. Reset value 0.
- `o_mem_wdata` out DATA_W: store data shifted into its byte lanes. Reset value 0.
- `o_mem_wmask` out 4: byte-lane enables. Reset value 0.
- `i_mem_gnt` in 1: memory accepts the request this cycle.
- `i_mem_rvalid` in 1: response (read data or write ack) is valid this cycle.
- `i_mem_rdata` in DATA_W: full word of read data.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE, `i_valid`=1:
  - Register op, size, address bits `[1:0]`, memory address, wmask and shifted wdata.
  - If the access is legal, go to REQ.
  - If it is illegal, go to DONE with `err`=1. No memory traffic occurs.
- Illegal access is any of:
  - `i_ld` equals `i_st` (both 0 or both 1);
  - an undefined `funct3` for the op;
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0.
- REQ:
  - `o_mem_req`=1, with `o_mem_we`, `o_mem_addr`, `o_mem_wdata` and `o_mem_wmask` stable.
  - On `i_mem_gnt`, go to WAIT.
  - `i_mem_rvalid` is ignored in REQ.
- WAIT:
  - `o_mem_req`=0.
  - On `i_mem_rvalid`, register the extended result into `o_rdata` (loads) or 0 (stores), then go to DONE.
- DONE: `o_done`=1, then go to IDLE unconditionally. `i_valid` seen in DONE is not accepted.
- Store lanes, with k = `addr[1:0]`:
  - SB: mask `4'b0001<<k`, wdata `{4{wdata[7:0]}}`.
  - SH: mask `4'b0011<<k`, wdata `{2{wdata[15:0]}}`.
  - SW: mask `4'b1111`, wdata unchanged.
  - For loads, mask is `4'b0000`.
- Load extraction:
  - Byte is `rdata>>(8k)` bits `[7:0]`; half is `rdata>>(8k)` bits `[15:0]`.
  - LB and LH sign-extend from bit 7 and bit 15. LBU and LHU zero-extend. LW passes the word through.
- `o_err` is cleared in IDLE and is only meaningful with `o_done`.

## Timing
- Legal access, minimum latency:
  - `i_valid` in cycle T;
  - `o_mem_req` in T+1, granted in the same cycle;
  - `i_mem_rvalid` in T+2;
  - `o_done` in T+3.
- `o_busy` is high from T to T+2 and low at T+3.
- Each cycle of grant delay adds one cycle; each cycle of response delay adds one cycle. No timeout.
- Illegal access: `o_done` and `o_err` at T+1. `o_mem_req` stays 0.
- `rst` mid-operation: next cycle is IDLE, `o_mem_req`=0 and `o_done`=0. Late `i_mem_rvalid` after reset is ignored in IDLE.
- Back-to-back accesses: a new `i_valid` is accepted in the cycle after DONE, so peak throughput is one access per 4 cycles.

## Test plan
- LW, `addr=0x80000104`, gnt at T+1, rvalid at T+2 with rdata `0xDEADBEEF`:
  - `o_mem_addr=0x80000104`, mask 0;
  - `o_done` at T+3 with `o_rdata=0xDEADBEEF`, `o_err`=0.
- LB and LBU at `addr=0x80000103`, rdata `0x80FF7F01`:
  - LB gives `0xFFFFFF80`; LBU gives `0x00000080`.
  - LH at `0x80000102` gives `0xFFFF80FF`.
- SB at `addr=0x80000201`, wdata `0x123456AB`:
  - `o_mem_we`=1, `o_mem_addr=0x80000200`, mask `4'b0010`, `o_mem_wdata=0xABABABAB`.
- SW at `addr=0x80000302`: `o_done` and `o_err`=1 at T+1, `o_mem_req` never asserted.
- LW with gnt held low 3 cycles and rvalid 2 cycles after gnt:
  - `o_mem_req` stays high for 4 cycles with address stable;
  - `o_done` at T+7;
  - `o_busy` high for T..T+6.
- `rst` asserted during WAIT, then rvalid arrives: IDLE after reset, no `o_done`. A following LW completes normally.
